// File: rtl/alu_pkg.sv
// Shared opcode encodings, controller states and flag bit positions for the
// sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_CMP  = 4'b0101;
    localparam logic [3:0] OP_ADDL = 4'b0110;
    localparam logic [3:0] OP_SHL  = 4'b0111;
    localparam logic [3:0] OP_SHR  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_SLT  = 4'b1010;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // flags vector is {N,Z,C,V}
    localparam int unsigned FLAG_V = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 3;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, full
// 2*WIDTH product, o_done pulses with the final product on o_product.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_a;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);
    // Iteration 0 is folded into the start cycle and the last iteration is
    // presented combinationally, so the caller can register the product on
    // the same edge that finishes it.
    assign o_done    = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign o_product = w_acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= CW'(1);
            r_acc  <= i_b[0] ? {{WIDTH{1'b0}}, i_a} : '0;
            r_a    <= {{(WIDTH-1){1'b0}}, i_a, 1'b0};
            r_b    <= i_b >> 1;
        end else if (r_busy) begin
            r_acc <= w_acc_next;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + CW'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops register straight into the output stage,
// MUL runs through the iterative multiplier while the controller sits in BUSY.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             compare,
    output logic [3:0]       flags,
    output logic             err
);

    localparam int unsigned MSB = WIDTH - 1;

    state_t             r_state;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;
    logic               r_compare;
    logic               r_err;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_nz_src;
    logic               w_c;
    logic               w_v;
    logic               w_cmp;
    logic               w_err;
    logic [3:0]         w_flags;
    logic [3:0]         w_mul_flags;

    assign in_ready = (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_start  = w_accept && (opcode == OP_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_start),
        .i_a       (data_in1),
        .i_b       (data_in2),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    assign w_shamt = data_in2[SHW-1:0];
    assign w_sum   = {1'b0, data_in1} + {1'b0, data_in2};
    assign w_diff  = {1'b0, data_in1} - {1'b0, data_in2};
    // One guard bit on each side catches the last bit shifted out.
    assign w_shl   = {1'b0, data_in1} << w_shamt;
    assign w_shr   = {data_in1, 1'b0} >> w_shamt;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_cmp = 1'b0;
        w_err = 1'b0;
        case (opcode)
            OP_ADD, OP_ADDL: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[WIDTH];
                w_v   = (data_in1[MSB] == data_in2[MSB]) && (w_sum[MSB] != data_in1[MSB]);
            end
            OP_SUB, OP_CMP: begin
                w_res = (opcode == OP_CMP) ? '0 : w_diff[MSB:0];
                w_cmp = (opcode == OP_CMP) && (data_in1 == data_in2);
                w_c   = w_diff[WIDTH];
                w_v   = (data_in1[MSB] != data_in2[MSB]) && (w_diff[MSB] != data_in1[MSB]);
            end
            OP_AND: w_res = data_in1 & data_in2;
            OP_OR:  w_res = data_in1 | data_in2;
            OP_XOR: w_res = data_in1 ^ data_in2;
            OP_SHL: begin
                w_res = w_shl[MSB:0];
                w_c   = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            OP_SLT: w_res[0] = $signed(data_in1) < $signed(data_in2);
            OP_MUL: ;
            default: w_err = 1'b1;
        endcase

        // CMP reports N/Z of the difference even though its result is zero.
        w_nz_src = (opcode == OP_CMP) ? w_diff[MSB:0] : w_res;
        w_flags  = '0;
        if (!w_err) begin
            w_flags[FLAG_N] = w_nz_src[MSB];
            w_flags[FLAG_Z] = (w_nz_src == '0);
            w_flags[FLAG_C] = w_c;
            w_flags[FLAG_V] = w_v;
        end

        w_mul_flags         = '0;
        w_mul_flags[FLAG_N] = w_product[MSB];
        w_mul_flags[FLAG_Z] = (w_product[MSB:0] == '0);
        w_mul_flags[FLAG_C] = |w_product[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_compare   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE:    if (w_start)    r_state <= BUSY;
                BUSY:    if (w_mul_done) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            if (w_accept && !w_start) begin
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_flags     <= w_flags;
                r_compare   <= w_cmp;
                r_err       <= w_err;
            end else if (w_mul_done) begin
                r_out_valid <= 1'b1;
                r_result    <= w_product[MSB:0];
                r_flags     <= w_mul_flags;
                r_compare   <= 1'b0;
                r_err       <= 1'b0;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;
    assign compare   = r_compare;
    assign err       = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): directed cases plus randomized traffic, all
// checked against an arithmetic reference model of the handshaked ALU.
module tb_alu_seq;

    localparam int W = 8;

    typedef struct {
        logic [7:0] res;
        logic [3:0] flg;
        logic       cmp;
        logic       err;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   opcode;
    logic [W-1:0] data_in1;
    logic [W-1:0] data_in2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         compare;
    logic [3:0]   flags;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    // model state: pending output valid, cycles left on a multiply, held values
    logic mv;
    int   busy_left;
    exp_t held;
    exp_t pending;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .data_in1  (data_in1),
        .data_in2  (data_in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .compare   (compare),
        .flags     (flags),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t calc(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int ua, ub, sa, sb, r, s, t, src;
        logic c, v, n, z;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        r = 0; c = 1'b0; v = 1'b0;
        e.cmp = 1'b0;
        e.err = 1'b0;
        case (op)
            4'd0, 4'd6: begin
                t = ua + ub;
                r = t % 256;
                c = (t > 255);
                v = (sa + sb > 127) || (sa + sb < -128);
            end
            4'd1, 4'd5: begin
                r = (op == 4'd5) ? 0 : (ua - ub + 256) % 256;
                e.cmp = (op == 4'd5) && (ua == ub);
                c = (ua < ub);
                v = (sa - sb > 127) || (sa - sb < -128);
            end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd7: begin
                s = ub % 8;
                t = ua << s;
                r = t % 256;
                c = (s != 0) && (((t >> 8) & 1) == 1);
            end
            4'd8: begin
                s = ub % 8;
                r = ua >> s;
                c = (s != 0) && (((ua >> (s - 1)) & 1) == 1);
            end
            4'd9: begin
                t = ua * ub;
                r = t % 256;
                c = (t > 255);
            end
            4'd10: r = (sa < sb) ? 1 : 0;
            default: e.err = 1'b1;
        endcase
        src = (op == 4'd5) ? (ua - ub + 256) % 256 : r;
        n = (src > 127);
        z = (src == 0);
        e.res = 8'(r);
        e.flg = e.err ? 4'b0000 : {n, z, c, v};
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Drives one cycle of stimulus, advances the model across the clock edge
    // and checks the DUT on the following falling edge.
    task automatic cycle(input logic r, input logic iv, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b, input logic ordy);
        logic exp_rdy;
        logic acc;
        exp_t e;
        rst       = r;
        in_valid  = iv;
        opcode    = op;
        data_in1  = a;
        data_in2  = b;
        out_ready = ordy;
        exp_rdy   = (busy_left == 0) && (!mv || ordy);
        #1;
        if (!r) chk("in_ready", in_ready, exp_rdy);
        acc = iv && exp_rdy && !r;
        e = calc(op, a, b);
        if (r) begin
            mv = 1'b0;
            busy_left = 0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                mv = 1'b1;
                held = pending;
            end
        end else begin
            if (mv && ordy) mv = 1'b0;
            if (acc) begin
                if (op == 4'd9) begin
                    pending = e;
                    busy_left = W - 1;
                end else begin
                    mv = 1'b1;
                    held = e;
                end
            end
        end
        @(negedge clk);
        chk("out_valid", out_valid, mv);
        if (r) begin
            chk("rst_result", result, 0);
            chk("rst_flags", flags, 0);
            chk("rst_compare", compare, 0);
            chk("rst_err", err, 0);
        end else if (mv) begin
            chk("result", result, held.res);
            chk("flags", flags, held.flg);
            chk("compare", compare, held.cmp);
            chk("err", err, held.err);
        end
    endtask

    task automatic expect_dut(input string nm, input logic [7:0] r, input logic [3:0] f,
                              input logic c, input logic e);
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_result"}, result, r);
        chk({nm, "_flags"}, flags, f);
        chk({nm, "_compare"}, compare, c);
        chk({nm, "_err"}, err, e);
    endtask

    initial begin
        exp_t e;
        int lat;
        logic [3:0] op;
        mv = 1'b0;
        busy_left = 0;
        held = '{res: 8'h00, flg: 4'h0, cmp: 1'b0, err: 1'b0};
        pending = held;

        cycle(1, 0, 4'd0, 8'h00, 8'h00, 1);
        cycle(1, 0, 4'd0, 8'h00, 8'h00, 1);
        out_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("reset_in_ready", in_ready, 1);

        e = calc(4'd0, 8'hF0, 8'h20);
        chk("pin_add", {e.res, e.flg}, {8'h10, 4'b0010});
        e = calc(4'd5, 8'h33, 8'h34);
        chk("pin_cmp", {e.res, e.flg, e.cmp}, {8'h00, 4'b1010, 1'b0});
        e = calc(4'd9, 8'h10, 8'h10);
        chk("pin_mul", {e.res, e.flg}, {8'h00, 4'b0110});
        e = calc(4'd7, 8'h81, 8'h01);
        chk("pin_shl", {e.res, e.flg}, {8'h02, 4'b0010});
        e = calc(4'd15, 8'h12, 8'h34);
        chk("pin_illegal", {e.res, e.flg, e.err}, {8'h00, 4'b0000, 1'b1});

        cycle(0, 1, 4'd0, 8'hF0, 8'h20, 1);
        expect_dut("add", 8'h10, 4'b0010, 0, 0);
        cycle(0, 1, 4'd1, 8'h05, 8'h05, 1);
        expect_dut("sub", 8'h00, 4'b0100, 0, 0);
        cycle(0, 1, 4'd5, 8'h33, 8'h33, 1);
        expect_dut("cmp_eq", 8'h00, 4'b0100, 1, 0);
        cycle(0, 1, 4'd5, 8'h33, 8'h34, 1);
        expect_dut("cmp_ne", 8'h00, 4'b1010, 0, 0);
        cycle(0, 1, 4'd10, 8'h80, 8'h01, 1);
        expect_dut("slt", 8'h01, 4'b0000, 0, 0);
        cycle(0, 1, 4'd7, 8'h81, 8'h01, 1);
        expect_dut("shl", 8'h02, 4'b0010, 0, 0);
        cycle(0, 1, 4'd8, 8'h81, 8'h00, 1);
        expect_dut("shr0", 8'h81, 4'b1000, 0, 0);
        cycle(0, 1, 4'd15, 8'h5A, 8'hA5, 1);
        expect_dut("illegal", 8'h00, 4'b0000, 0, 1);

        cycle(0, 1, 4'd9, 8'h0F, 8'h11, 1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            cycle(0, 1, 4'd0, 8'h01, 8'h01, 0);
            lat++;
        end
        chk("mul_latency", lat, 8);
        expect_dut("mul_ff", 8'hFF, 4'b1000, 0, 0);

        cycle(0, 1, 4'd9, 8'h10, 8'h10, 1);
        for (int i = 0; i < 7; i++) cycle(0, 0, 4'd0, 8'h00, 8'h00, 0);
        expect_dut("mul_ovf", 8'h00, 4'b0110, 0, 0);

        cycle(0, 1, 4'd4, 8'hAA, 8'h55, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 4'd2, 8'h0F, 8'h3C, 0);
            expect_dut("stall_hold", 8'hFF, 4'b1000, 0, 0);
        end
        cycle(0, 1, 4'd2, 8'h0F, 8'h3C, 1);
        expect_dut("drain_and", 8'h0C, 4'b0000, 0, 0);
        cycle(0, 1, 4'd3, 8'h80, 8'h01, 1);
        expect_dut("b2b_or", 8'h81, 4'b1000, 0, 0);

        cycle(0, 1, 4'd9, 8'h07, 8'h09, 1);
        cycle(0, 1, 4'd0, 8'h00, 8'h00, 0);
        cycle(0, 1, 4'd0, 8'h00, 8'h00, 0);
        cycle(1, 0, 4'd0, 8'h00, 8'h00, 0);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        cycle(0, 1, 4'd0, 8'h01, 8'h01, 1);
        expect_dut("post_abort_add", 8'h02, 4'b0000, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 4'd0, 8'h00, 8'h00, 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(11, 15));
            else                           op = 4'($urandom_range(0, 10));
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 7),
                  op,
                  8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)),
                  ($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 12; i++) cycle(0, 0, 4'd0, 8'h00, 8'h00, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the 8-bit combinational datapath ALU. It keeps the existing opcode encodings 0000–0110 and adds shifts, set-less-than and an iterative multiply. Results and a 4-bit status flag set are registered behind a valid/ready interface, so the controller can stall on multi-cycle operations. It sits between the register-file read ports and the writeback/branch logic.

Parameters:
WIDTH, 8, data width of operands and result (≥4, power of 2)
SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands/opcode valid
in_ready  out  1  block can accept an operation this cycle
opcode  in  4  operation select
data_in1  in  WIDTH  operand A
data_in2  in  WIDTH  operand B (shift amount = data_in2[SHW-1:0])
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
compare  out  1  CMP equality outcome
flags  out  4  {N,Z,C,V}
err  out  1  illegal opcode flagged with this result

Behaviour:
- Reset: the controller FSM and all outputs clear; result, flags, compare, err and out_valid are 0; the FSM enters IDLE. in_ready is 1 in the first cycle after reset deasserts.
- Reset mid-operation: aborts any MUL in progress and discards any pending result. No stale out_valid may appear.
- Accept: an operation is accepted when in_valid && in_ready on a rising edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready). The block accepts a new operation in the same cycle a result drains.
- FSM states:
  - IDLE: accept; single-cycle ops stay in IDLE; MUL goes to BUSY.
  - BUSY: counter runs 0..WIDTH-1, then goes to IDLE and loads the output register.
- Latency:
  - Single-cycle ops: out_valid rises one cycle after accept.
  - MUL: out_valid rises WIDTH cycles after accept; in_ready is 0 throughout BUSY.
- Output hold: out_valid and all outputs hold stable until out_valid && out_ready. out_valid then drops, unless a new accept in the same cycle reloads it.
- Opcodes:
  - 0000 ADD; C = carry-out; V = signed overflow.
  - 0001 SUB; C = borrow (A<B unsigned); V = signed overflow.
  - 0010 AND, 0011 OR, 0100 XOR; C = V = 0.
  - 0101 CMP: result = 0; compare = (A==B); flags computed from A-B.
  - 0110 ADDL: same as ADD (address calculation for loads).
  - 0111 SHL: C = last bit shifted out; shift of 0 gives C = 0.
  - 1000 SHR (logical): C = last bit shifted out; shift of 0 gives C = 0.
  - 1001 MUL: shift-add, low WIDTH bits of the product; C = 1 if the upper WIDTH bits are nonzero; V = 0.
  - 1010 SLT (signed): result = {0…,A<B}; C = V = 0.
  - Others: result = 0, flags = 0, err = 1.
- compare: 0 for every op except CMP.
- Flags for all ops: N = result[WIDTH-1]; Z = (result==0).
- Operand capture: operands are registered on accept. Input changes during BUSY are ignored.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD..OP_SLT;
  - state enum {IDLE, BUSY};
  - flag bit index constants FLAG_N/Z/C/V.
- Sub-module alu_mul_iter: start/done iterative shift-add multiplier with WIDTH-cycle latency and 2·WIDTH product. alu_seq instantiates it and owns the handshake and output register.

Test Plan:
- WIDTH=8, ADD 0xF0+0x20 -> result 0x10, C=1, Z=0, V=0, out_valid one cycle after accept; SUB 0x05-0x05 -> 0x00, Z=1, C=0.
- CMP 0x33,0x33 -> compare=1, result 0x00; CMP 0x33,0x34 -> compare=0, N=1, C=1; SLT 0x80,0x01 -> result 0x01.
- MUL 0x0F×0x11 -> 0xFF, C=0, out_valid exactly 8 cycles after accept, in_ready=0 throughout; MUL 0x10×0x10 -> 0x00, Z=1, C=1.
- SHL 0x81 by 1 -> 0x02, C=1; SHR 0x81 by 0 -> 0x81, C=0; opcode 1111 -> result 0, err=1.
- Backpressure: out_ready=0 for 3 cycles -> result/flags stable, in_ready=0; an accept in the cycle out_ready=1 gives back-to-back results with no bubble.
- Assert rst in BUSY cycle 3 -> next cycle out_valid=0, in_ready=1; a following ADD 1+1 returns 0x02 with no leftover MUL result.
